c2c_mem_arbiter: RTL and testbench
==================================

// Module: c2c_mem_arbiter
// PURPOSE
//   Downstream of the core: merges the core's three c2c master buses (instruction read, data read,
//   data write) onto one single-ported memory c2c port. One transaction outstanding at a time;
//   fair between instruction fetch and data traffic so neither side starves.
// PARAMETERS
//   XLEN  32  data/address width of data buses and memory port; instruction data fixed at 32 bits
// PORTS
//   clk         in   1        clock, all state on rising edge
//   reset_n     in   1        asynchronous, active-low reset
//   instr_re    in   1        instruction read request (held until instr_ack)
//   instr_sel   in   XLEN/8   instruction byte selects
//   instr_addr  in   XLEN     instruction address
//   instr_ack   out  1        one-cycle completion pulse to instruction master
//   instr_data  out  32       fetched word, valid with instr_ack
//   dr_re       in   1        data read request (held until dr_ack)
//   dr_sel      in   XLEN/8   data read byte selects
//   dr_addr     in   XLEN     data read address
//   dr_ack      out  1        one-cycle completion pulse to data read master
//   dr_data     out  XLEN     read data, valid with dr_ack
//   dw_we       in   1        data write request (held until dw_ack)
//   dw_sel      in   XLEN/8   data write byte selects
//   dw_addr     in   XLEN     data write address
//   dw_data     in   XLEN     write data
//   dw_ack      out  1        one-cycle completion pulse to data write master
//   mem_re      out  1        memory read strobe, held until mem_ack
//   mem_we      out  1        memory write strobe, held until mem_ack
//   mem_sel     out  XLEN/8   memory byte selects
//   mem_addr    out  XLEN     memory address
//   mem_wdata   out  XLEN     memory write data
//   mem_ack     in   1        memory completion pulse (any latency >= 1 cycle after strobe)
//   mem_rdata   in   XLEN     memory read data, valid with mem_ack
// BEHAVIOUR
// - FSM states: IDLE, GNT_I, GNT_DR, GNT_DW. Reset -> IDLE, prio_i=0, all mem_* registers 0.
// - IDLE: pick winner from requests sampled this cycle; on next edge latch winner's addr/sel/(data)
//   into mem_* registers, assert mem_re (GNT_I, GNT_DR) or mem_we (GNT_DW), enter matching GNT state.
// - Selection: if prio_i && instr_re -> I; else dw_we -> DW; else dr_re -> DR; else instr_re -> I.
//   Granting DW/DR sets prio_i=1; granting I clears prio_i. No request -> stay IDLE.
// - GNT_x: mem_* registers held constant until mem_ack; on mem_ack cycle the granted port's ack is
//   driven combinationally (=mem_ack) and mem_rdata forwarded (instr_data = mem_rdata[31:0]);
//   next edge: mem_re/mem_we cleared, return to IDLE.
// - Acks/data of non-granted ports are 0; all *_data outputs are 0 whenever their ack is 0.
// - mem_re and mem_we never both 1. mem_ack outside GNT_x is ignored.
// - Latency: request first seen in IDLE at cycle N -> mem strobe at N+1 -> port ack in same cycle as
//   mem_ack (cycle M) -> IDLE at M+1 -> next strobe earliest M+2 (one dead cycle; masters drop their
//   request the cycle after ack, so no duplicate grant).
// - Request withdrawn before ack (protocol violation): latched transaction still completes, ack
//   still pulsed; no abort path.
// - Reset mid-transaction: immediately IDLE, strobes and acks 0; outstanding memory op abandoned
//   (memory shares reset_n).
// TESTING
// - Reset asserted in GNT_DR with mem_ack pending -> mem_re=0, dr_ack=0 same cycle; IDLE after release.
// - instr_re alone, addr 0x100, mem_ack 2 cycles after mem_re, rdata 0x00000013 -> one
//   instr_ack pulse with instr_data=0x13, mem_addr=0x100, IDLE next cycle.
// - dw_we addr 0x200 data 0xDEADBEEF sel 0xF -> mem_we=1, mem_wdata=0xDEADBEEF held until
//   mem_ack; dw_ack pulses once; mem_re stays 0 throughout.
// - instr_re, dr_re, dw_we all raised same cycle, held until acked -> grant order DW, I, DR; each ack
//   exactly once, dead IDLE cycle between grants.
// - instr_re continuously held (re-raised after each ack) plus back-to-back dr_re -> grants alternate
//   DR, I, DR, I; no request waits more than one other transaction.
// - Spurious mem_ack in IDLE -> no port ack, no state change; mem_ack held high 3 cycles in GNT_I
//   -> single instr_ack pulse.

Source files
------------

// File: rtl/c2c_mem_arbiter.sv
`timescale 1ns/1ps
// Merges instruction-read, data-read and data-write c2c masters onto one memory port, one transaction at a time.
// Strobe one cycle after a request is seen in IDLE; port ack is mem_ack itself; masters wait (hold request) until acked.
module c2c_mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_re,
  input  logic [XLEN/8-1:0] instr_sel,
  input  logic [XLEN-1:0]   instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              dr_re,
  input  logic [XLEN/8-1:0] dr_sel,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_ack,
  output logic [XLEN-1:0]   dr_data,
  input  logic              dw_we,
  input  logic [XLEN/8-1:0] dw_sel,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_data,
  output logic              dw_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_DR, GNT_DW} state_t;

  state_t            state_q, state_d;
  logic              prio_i_q, prio_i_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN/8-1:0] mem_sel_q, mem_sel_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              grant_i;

  // Fetch wins when it is owed a turn, or when no data traffic competes.
  assign grant_i = instr_re && (prio_i_q || !(dw_we || dr_re));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_i_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_i_q    <= prio_i_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_i_d    = prio_i_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d    = GNT_I;
          prio_i_d   = 1'b0;
          mem_re_d   = 1'b1;
          mem_sel_d  = instr_sel;
          mem_addr_d = instr_addr;
        end else if (dw_we) begin
          state_d     = GNT_DW;
          prio_i_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_sel_d   = dw_sel;
          mem_addr_d  = dw_addr;
          mem_wdata_d = dw_data;
        end else if (dr_re) begin
          state_d    = GNT_DR;
          prio_i_d   = 1'b1;
          mem_re_d   = 1'b1;
          mem_sel_d  = dr_sel;
          mem_addr_d = dr_addr;
        end
      end
      GNT_I, GNT_DR, GNT_DW: begin
        if (mem_ack) begin
          state_d  = IDLE;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign instr_ack  = (state_q == GNT_I)  && mem_ack;
  assign dr_ack     = (state_q == GNT_DR) && mem_ack;
  assign dw_ack     = (state_q == GNT_DW) && mem_ack;
  assign instr_data = instr_ack ? mem_rdata[31:0] : 32'h0;
  assign dr_data    = dr_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_c2c_mem_arbiter.sv
`timescale 1ns/1ps
// Directed scenarios plus a randomized run of three masters and a memory responder, scored against a transaction-level model.
module tb_c2c_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_re, dr_re, dw_we, mem_ack;
  logic [3:0]  instr_sel, dr_sel, dw_sel;
  logic [31:0] instr_addr, dr_addr, dw_addr, dw_data, mem_rdata;
  logic        instr_ack, dr_ack, dw_ack, mem_re, mem_we;
  logic [31:0] instr_data, dr_data, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;

  c2c_mem_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr), .dr_ack(dr_ack), .dr_data(dr_data),
    .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data), .dw_ack(dw_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Masters: index 0 = instruction read, 1 = data read, 2 = data write.
  bit          req[3];
  logic [31:0] a[3];
  logic [3:0]  s[3];
  logic [31:0] wd;
  bit          persist[3];
  bit          ackp[3];
  bit          rand_mode, mem_manual;
  int          resp_cnt;

  // Reference model: at most one transaction in flight, plus whether fetch is owed the next turn.
  bit          m_busy, m_owe_i;
  int          m_port;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;

  int          ack_log[$];
  logic [31:0] last_idata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int winner();
    if (req[0] && m_owe_i) return 0;
    if (req[2]) return 2;
    if (req[1]) return 1;
    if (req[0]) return 0;
    return -1;
  endfunction

  task automatic apply_ports();
    instr_re = req[0]; instr_addr = a[0]; instr_sel = s[0];
    dr_re    = req[1]; dr_addr    = a[1]; dr_sel    = s[1];
    dw_we    = req[2]; dw_addr    = a[2]; dw_sel    = s[2]; dw_data = wd;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owe_i = 0; m_port = -1; resp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 0; ackp[k] = 0; a[k] = '0; s[k] = '0;
    end
    wd = '0;
  endtask

  // Master behaviour and memory responder for one cycle; called just after a rising edge.
  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      if (req[k] && ackp[k]) req[k] = 0;
      else if (!req[k] && (persist[k] || (rand_mode && $urandom_range(0, 3) == 0))) begin
        req[k] = 1;
        a[k] = $urandom;
        s[k] = 4'($urandom_range(1, 15));
        if (k == 2) wd = $urandom;
      end
    end
    if (!mem_manual) begin
      if (m_busy) begin
        if (resp_cnt == 0) mem_ack = 1'b1;
        else begin mem_ack = 1'b0; resp_cnt--; end
      end else mem_ack = ($urandom_range(0, 7) == 0);
    end
    mem_rdata = $urandom;
    apply_ports();
  endtask

  // Compare outputs mid-cycle against the model, then advance the model across the edge.
  task automatic tick();
    bit exp_ack[3];
    int w;
    #1;
    for (int k = 0; k < 3; k++) exp_ack[k] = m_busy && (m_port == k) && mem_ack;
    chk("mem_re", mem_re, m_busy && m_port != 2);
    chk("mem_we", mem_we, m_busy && m_port == 2);
    chk("instr_ack", instr_ack, exp_ack[0]);
    chk("dr_ack", dr_ack, exp_ack[1]);
    chk("dw_ack", dw_ack, exp_ack[2]);
    chk("instr_data", instr_data, exp_ack[0] ? mem_rdata : 32'h0);
    chk("dr_data", dr_data, exp_ack[1] ? mem_rdata : 32'h0);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_sel", mem_sel, m_sel);
      if (m_port == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (instr_ack) begin ack_log.push_back(0); last_idata = instr_data; end
    if (dr_ack) ack_log.push_back(1);
    if (dw_ack) ack_log.push_back(2);
    for (int k = 0; k < 3; k++) ackp[k] = exp_ack[k];
    @(posedge clk);
    if (m_busy) begin
      if (mem_ack) m_busy = 0;
    end else begin
      w = winner();
      if (w >= 0) begin
        m_busy = 1; m_port = w; m_addr = a[w]; m_sel = s[w]; m_wdata = wd;
        m_owe_i = (w != 0);
        resp_cnt = int'($urandom_range(1, 3));
      end
    end
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    mem_ack = 1'b0; mem_rdata = '0;
    apply_ports();
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    ack_log.delete();
  endtask

  initial begin
    rand_mode = 0; mem_manual = 1;
    for (int k = 0; k < 3; k++) persist[k] = 0;
    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_instr_ack", instr_ack, 0);
    do_reset();

    // Lone fetch from 0x100, memory answers two cycles after the strobe.
    drive(); req[0] = 1; a[0] = 32'h100; s[0] = 4'hF; apply_ports(); mem_ack = 0; tick();
    chk("i_addr", mem_addr, 32'h100);
    chk("i_strobe", mem_re, 1);
    drive(); mem_ack = 0; tick();
    drive(); mem_ack = 0; tick();
    drive(); mem_ack = 1; mem_rdata = 32'h13; tick();
    chk("i_back_idle", mem_re, 0);
    drive(); mem_ack = 0; tick();
    chk("i_ack_count", ack_log.size(), 1);
    chk("i_data", last_idata, 32'h13);

    // Single write.
    ack_log.delete();
    drive(); req[2] = 1; a[2] = 32'h200; s[2] = 4'hF; wd = 32'hDEADBEEF; apply_ports();
    mem_ack = 0; tick();
    chk("w_we", mem_we, 1);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_addr", mem_addr, 32'h200);
    drive(); mem_ack = 0; tick();
    drive(); mem_ack = 1; tick();
    drive(); mem_ack = 0; tick();
    chk("w_ack_count", ack_log.size(), 1);

    // All three masters at once from a fresh reset: write, then fetch, then read.
    do_reset();
    mem_manual = 0;
    drive();
    for (int k = 0; k < 3; k++) begin req[k] = 1; a[k] = 32'h1000 + 32'(k * 16); s[k] = 4'h3; end
    wd = 32'hCAFEF00D; apply_ports();
    tick();
    for (int c = 0; c < 40 && ack_log.size() < 3; c++) begin drive(); tick(); end
    chk("all3_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk("all3_first", ack_log[0], 2);
      chk("all3_second", ack_log[1], 0);
      chk("all3_third", ack_log[2], 1);
    end

    // Persistent fetch against back-to-back data reads must alternate.
    do_reset();
    persist[0] = 1; persist[1] = 1;
    for (int c = 0; c < 60 && ack_log.size() < 4; c++) begin drive(); tick(); end
    persist[0] = 0; persist[1] = 0;
    chk("alt_count", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      chk("alt_0", ack_log[0], 1);
      chk("alt_1", ack_log[1], 0);
      chk("alt_2", ack_log[2], 1);
      chk("alt_3", ack_log[3], 0);
    end
    for (int c = 0; c < 20; c++) begin drive(); tick(); end

    // Spurious acks in IDLE, then ack held three cycles over a fetch.
    do_reset();
    mem_manual = 1;
    drive(); mem_ack = 1; tick();
    drive(); mem_ack = 1; tick();
    chk("spur_none", ack_log.size(), 0);
    chk("spur_idle", mem_re, 0);
    drive(); req[0] = 1; a[0] = 32'h44; s[0] = 4'h1; apply_ports(); mem_ack = 0; tick();
    for (int c = 0; c < 3; c++) begin drive(); mem_ack = 1; tick(); end
    drive(); mem_ack = 0; tick();
    chk("held_ack_count", ack_log.size(), 1);

    // Reset while a data read waits on a pending mem_ack.
    do_reset();
    drive(); req[1] = 1; a[1] = 32'h300; s[1] = 4'hC; apply_ports(); mem_ack = 0; tick();
    chk("rst_gnt_re", mem_re, 1);
    mem_ack = 1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_re", mem_re, 0);
    chk("rst_mid_ack", dr_ack, 0);
    chk("rst_mid_data", dr_data, 0);
    model_reset(); apply_ports(); mem_ack = 0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    drive(); tick();
    chk("rst_after_re", mem_re, 0);
    drive(); tick();

    // Randomized traffic with random memory latency and stray acks.
    do_reset();
    mem_manual = 0; rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin drive(); tick(); end
    rand_mode = 0;
    for (int c = 0; c < 40; c++) begin drive(); tick(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
